// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - parametrised AHB-Lite memory slave
// Purpose: word-organised memory on an AHB-Lite bus with separate NONSEQ/SEQ
//   wait states, byte-lane writes and read-after-write forwarding.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS   address phase: select, byte address, transfer type
//   HWRITE, HSIZE         address phase: direction, transfer size
//   HREADYIN              bus HREADY (previous transfer finished)
//   HWDATA                write data (data phase)
//   HRDATA, HREADYOUT     read data, slave ready
//   HRESP                 00 OKAY, 01 ERROR
// Option: define AHB_MEM_ERR_INJECT_EN to answer addresses beyond MEM_DEPTH
//   words with a two-cycle ERROR response; otherwise they wrap modulo MEM_DEPTH.
module ahb_mem_slave #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int MEM_DEPTH       = 256,
  parameter int WAIT_STATES     = 0,
  parameter int SEQ_WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADYIN,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);

`ifdef AHB_MEM_ERR_INJECT_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [2:0]        size_q, size_d;
  logic [LSB-1:0]    off_q, off_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              hready_out;
  logic              capture;
  logic              commit;
  logic [IDX_W-1:0]  new_idx;
  logic [3:0]        wait_ld;
  logic [2:0]        sz;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic              new_err;
  logic              unused_haddr;

  assign unused_haddr = ^HADDR;

  // Ready depends on state only, so the capture term below has no loop.
  always_comb begin
    hready_out = 1'b1;
    case (state_q)
      S_WAIT: hready_out = 1'b0;
`ifdef AHB_MEM_ERR_INJECT_EN
      S_ERR1: hready_out = 1'b0;
`endif
      default: hready_out = 1'b1;
    endcase
  end

  assign HREADYOUT = hready_out;
  assign HRDATA    = rdata_q;

`ifdef AHB_MEM_ERR_INJECT_EN
  assign HRESP   = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
  assign new_err = (HADDR >> (LSB + IDX_W)) != '0;
`else
  assign HRESP   = 2'b00;
  assign new_err = 1'b0;
`endif

  assign capture = HSEL & HTRANS[1] & HREADYIN & hready_out;
  assign new_idx = HADDR[LSB +: IDX_W];
  assign wait_ld = HTRANS[0] ? 4'(SEQ_WAIT_STATES) : 4'(WAIT_STATES);
  assign commit  = (state_q == S_DATA) && wr_q;

  // Byte lanes: a lane is written when it falls in the same naturally
  // aligned group of 2**sz bytes as the access offset. Oversized accesses
  // collapse to a full-word group.
  always_comb begin
    be      = '0;
    wr_word = mem[idx_q];
    sz      = (size_q > 3'(LSB)) ? 3'(LSB) : size_q;
    for (int b = 0; b < NB; b++) begin
      be[b] = ((3'(b) >> sz) == (3'(off_q) >> sz));
      if (be[b]) begin
        wr_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // A read captured while a write commits to the same word sees the merged word.
  assign rd_word = (commit && (idx_q == new_idx)) ? wr_word : mem[new_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DATA;
          if (!wr_q) begin
            rdata_d = mem[idx_q];
          end
        end
      end
`ifdef AHB_MEM_ERR_INJECT_EN
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    // Capture is only possible in ready states, so it overrides the above.
    if (capture) begin
      idx_d  = new_idx;
      wr_d   = HWRITE;
      size_d = HSIZE;
      off_d  = HADDR[LSB-1:0];
      if (new_err) begin
`ifdef AHB_MEM_ERR_INJECT_EN
        state_d = S_ERR1;
`endif
      end else if (wait_ld == 4'd0) begin
        state_d = S_DATA;
        if (!HWRITE) begin
          rdata_d = rd_word;
        end
      end else begin
        state_d = S_WAIT;
        cnt_d   = wait_ld;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      mem[idx_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - scoreboard bench for ahb_mem_slave
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hreset;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          dsel;

  logic [2:0]  hsel;
  logic [31:0] hrdata0, hrdata1, hrdata2;
  logic        hready0, hready1, hready2;
  logic [1:0]  hresp0, hresp1, hresp2;

  assign hsel[0] = hsel_bus && (dsel == 0);
  assign hsel[1] = hsel_bus && (dsel == 1);
  assign hsel[2] = hsel_bus && (dsel == 2);

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(0), .SEQ_WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hready0), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HREADYOUT(hready0), .HRESP(hresp0));

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(2), .SEQ_WAIT_STATES(1)) u_dut1 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hready1), .HWDATA(hwdata),
    .HRDATA(hrdata1), .HREADYOUT(hready1), .HRESP(hresp1));

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(3), .SEQ_WAIT_STATES(0)) u_dut2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hready2), .HWDATA(hwdata),
    .HRDATA(hrdata2), .HREADYOUT(hready2), .HRESP(hresp2));

  logic [31:0] hrdata_m;
  logic        hready_m;
  logic [1:0]  hresp_m;

  always_comb begin
    case (dsel)
      0:       begin hrdata_m = hrdata0; hready_m = hready0; hresp_m = hresp0; end
      1:       begin hrdata_m = hrdata1; hready_m = hready1; hresp_m = hresp1; end
      default: begin hrdata_m = hrdata2; hready_m = hready2; hresp_m = hresp2; end
    endcase
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [3][256];

  logic [31:0] t_addr  [16];
  logic        t_write [16];
  logic [2:0]  t_size  [16];
  logic [1:0]  t_trans [16];
  logic [31:0] t_wdata [16];
  int          stalls  [16];
  logic [1:0]  resp_first [16];
  logic [1:0]  resp_last  [16];

  // Scoreboard monitor: pops the expected word when a read data phase completes.
  bit          mon_dp = 1'b0;
  bit          mon_rd = 1'b0;
  logic [31:0] mon_exp;

  always @(negedge hclk) begin
    if (hreset) begin
      mon_dp = 1'b0;
    end else begin
      if (mon_dp && hready_m) begin
        if (mon_rd) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_scoreboard: got %h with no expected read queued", hrdata_m);
          end else begin
            mon_exp = exp_q.pop_front();
            if (hrdata_m !== mon_exp) begin
              bad++;
              $display("FAIL rd_data dut%0d: got %h expected %h", dsel, hrdata_m, mon_exp);
            end
          end
        end
        mon_dp = 1'b0;
      end
      if (!mon_dp && hsel_bus && htrans[1] && hready_m) begin
        mon_dp = 1'b1;
        mon_rd = !hwrite;
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] addr, input logic [2:0] size);
    logic [3:0]  lanes;
    logic [31:0] r;
    case (size)
      3'd0:    lanes = 4'b0001 << addr[1:0];
      3'd1:    lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic beat(input int k, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [1:0] trans, input logic [31:0] wd);
    t_addr[k] = addr; t_write[k] = wr; t_size[k] = size; t_trans[k] = trans; t_wdata[k] = wd;
  endtask

  task automatic set_addr(input int k, input int n);
    if (k < n) begin
      hsel_bus = 1'b1; haddr = t_addr[k]; htrans = t_trans[k];
      hwrite = t_write[k]; hsize = t_size[k];
    end else begin
      hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    end
  endtask

  task automatic accept(input int k);
    int idx;
    idx = int'((t_addr[k] >> 2) & 32'hFF);
    if (t_write[k]) begin
`ifdef AHB_MEM_ERR_INJECT_EN
      if (t_addr[k] < 32'h400)
`endif
        model[dsel][idx] = merge(model[dsel][idx], t_wdata[k], t_addr[k], t_size[k]);
    end else begin
      exp_q.push_back(model[dsel][idx]);
    end
  endtask

  // Pipelined driver for beats 0..n-1 of the stimulus table.
  task automatic run_seq(input int n);
    int ai, di, guard;
    bit rdy;
    for (int k = 0; k < n; k++) begin
      stalls[k] = 0; resp_first[k] = 2'b11; resp_last[k] = 2'b11;
    end
    ai = 0; di = -1; guard = 0;
    @(posedge hclk); #1;
    set_addr(0, n);
    while ((ai < n || di >= 0) && guard < 200) begin
      @(negedge hclk);
      rdy = hready_m;
      if (di >= 0) begin
        if (!rdy) begin
          stalls[di]++;
          if (stalls[di] == 1) resp_first[di] = hresp_m;
        end else begin
          if (stalls[di] == 0) resp_first[di] = hresp_m;
          resp_last[di] = hresp_m;
        end
      end
      @(posedge hclk); #1;
      guard++;
      if (rdy) begin
        if (ai < n) begin
          accept(ai);
          di = ai;
          ai++;
        end else begin
          di = -1;
        end
        if (di >= 0) hwdata = t_wdata[di];
        set_addr(ai, n);
      end
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL run_seq_timeout: beats left %0d, allowed 0", n - ai);
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1; hsel_bus = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0; dsel = 0;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    total += 9;
    if (hready0 !== 1'b1) begin bad++; $display("FAIL reset_hready0: got %b expected 1", hready0); end
    if (hready1 !== 1'b1) begin bad++; $display("FAIL reset_hready1: got %b expected 1", hready1); end
    if (hready2 !== 1'b1) begin bad++; $display("FAIL reset_hready2: got %b expected 1", hready2); end
    if (hresp0 !== 2'b00) begin bad++; $display("FAIL reset_hresp0: got %b expected 00", hresp0); end
    if (hresp1 !== 2'b00) begin bad++; $display("FAIL reset_hresp1: got %b expected 00", hresp1); end
    if (hresp2 !== 2'b00) begin bad++; $display("FAIL reset_hresp2: got %b expected 00", hresp2); end
    if (hrdata0 !== 32'h0) begin bad++; $display("FAIL reset_hrdata0: got %h expected 0", hrdata0); end
    if (hrdata1 !== 32'h0) begin bad++; $display("FAIL reset_hrdata1: got %h expected 0", hrdata1); end
    if (hrdata2 !== 32'h0) begin bad++; $display("FAIL reset_hrdata2: got %h expected 0", hrdata2); end
  endtask

  task automatic test_zero_wait_burst();
    dsel = 0;
    beat(0, 32'h0, 1'b1, 3'd2, 2'b10, 32'hAABBCCDD);
    beat(1, 32'h4, 1'b1, 3'd2, 2'b11, 32'h11223344);
    beat(2, 32'h8, 1'b1, 3'd2, 2'b11, 32'h55667788);
    beat(3, 32'hC, 1'b1, 3'd2, 2'b11, 32'h99AABBCC);
    run_seq(4);
    beat(0, 32'h0, 1'b0, 3'd2, 2'b10, 32'h0);
    beat(1, 32'h4, 1'b0, 3'd2, 2'b11, 32'h0);
    beat(2, 32'h8, 1'b0, 3'd2, 2'b11, 32'h0);
    beat(3, 32'hC, 1'b0, 3'd2, 2'b11, 32'h0);
    run_seq(4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (stalls[k] !== 0) begin
        bad++; $display("FAIL burst_ready beat%0d: low cycles %0d expected 0", k, stalls[k]);
      end
    end
  endtask

  task automatic test_wait_states();
    dsel = 1;
    beat(0, 32'h10, 1'b1, 3'd2, 2'b10, 32'hDEADBEEF);
    beat(1, 32'h14, 1'b1, 3'd2, 2'b11, 32'hCAFEF00D);
    run_seq(2);
    total += 2;
    if (stalls[0] !== 2) begin bad++; $display("FAIL wait_nonseq_wr: low cycles %0d expected 2", stalls[0]); end
    if (stalls[1] !== 1) begin bad++; $display("FAIL wait_seq_wr: low cycles %0d expected 1", stalls[1]); end
    beat(0, 32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
    beat(1, 32'h14, 1'b0, 3'd2, 2'b11, 32'h0);
    run_seq(2);
    total += 2;
    if (stalls[0] !== 2) begin bad++; $display("FAIL wait_nonseq_rd: low cycles %0d expected 2", stalls[0]); end
    if (stalls[1] !== 1) begin bad++; $display("FAIL wait_seq_rd: low cycles %0d expected 1", stalls[1]); end
  endtask

  task automatic test_forwarding();
    dsel = 0;
    beat(0, 32'h8, 1'b1, 3'd2, 2'b10, 32'h12345678);
    beat(1, 32'h8, 1'b0, 3'd2, 2'b10, 32'h0);
    run_seq(2);
  endtask

  task automatic test_byte_lane();
    dsel = 0;
    beat(0, 32'h5, 1'b1, 3'd0, 2'b10, 32'h0000AA00);
    beat(1, 32'h4, 1'b0, 3'd2, 2'b10, 32'h0);
    beat(2, 32'h6, 1'b1, 3'd1, 2'b10, 32'hBEEF0000);
    beat(3, 32'h4, 1'b0, 3'd2, 2'b10, 32'h0);
    beat(4, 32'hC, 1'b1, 3'd3, 2'b10, 32'h01020304);
    beat(5, 32'hC, 1'b0, 3'd2, 2'b10, 32'h0);
    run_seq(6);
  endtask

  task automatic test_err_inject();
    int         exp_st;
    logic [1:0] exp_r;
`ifdef AHB_MEM_ERR_INJECT_EN
    exp_st = 1; exp_r = 2'b01;
`else
    exp_st = 0; exp_r = 2'b00;
`endif
    dsel = 0;
    beat(0, 32'h400, 1'b1, 3'd2, 2'b10, 32'hFEEDFACE);
    beat(1, 32'h0,   1'b0, 3'd2, 2'b10, 32'h0);
    run_seq(2);
    total += 4;
    if (stalls[0] !== exp_st) begin bad++; $display("FAIL err_low_cycles: got %0d expected %0d", stalls[0], exp_st); end
    if (resp_first[0] !== exp_r) begin bad++; $display("FAIL err_resp_first: got %b expected %b", resp_first[0], exp_r); end
    if (resp_last[0] !== exp_r) begin bad++; $display("FAIL err_resp_last: got %b expected %b", resp_last[0], exp_r); end
    if (resp_last[1] !== 2'b00) begin bad++; $display("FAIL err_next_okay: got %b expected 00", resp_last[1]); end
  endtask

  task automatic test_reset_wait();
    dsel = 2;
    beat(0, 32'h20, 1'b1, 3'd2, 2'b10, 32'h5A5A5A5A);
    run_seq(1);
    beat(0, 32'h20, 1'b0, 3'd2, 2'b10, 32'h0);
    run_seq(1);
    total++;
    if (stalls[0] !== 3) begin bad++; $display("FAIL rw_wait_rd: low cycles %0d expected 3", stalls[0]); end
    @(posedge hclk); #1;
    hsel_bus = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h12121212;
    @(negedge hclk);
    total++;
    if (hready_m !== 1'b0) begin bad++; $display("FAIL rw_wait1_ready: got %b expected 0", hready_m); end
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(negedge hclk);
    total++;
    if (hready_m !== 1'b0) begin bad++; $display("FAIL rw_wait2_ready: got %b expected 0", hready_m); end
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    total += 3;
    if (hready_m !== 1'b1) begin bad++; $display("FAIL rw_post_ready: got %b expected 1", hready_m); end
    if (hresp_m !== 2'b00) begin bad++; $display("FAIL rw_post_resp: got %b expected 00", hresp_m); end
    if (hrdata_m !== 32'h0) begin bad++; $display("FAIL rw_post_rdata: got %h expected 0", hrdata_m); end
    run_seq(1);
  endtask

  initial begin
    test_reset();
    test_zero_wait_burst();
    test_wait_states();
    test_forwarding();
    test_byte_lane();
    test_err_inject();
    test_reset_wait();
    repeat (2) @(posedge hclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Parametrised AHB-Lite memory slave. It succeeds the fixed-depth, zero-wait mock peripheral used as source and destination in the DMAC top-level benches.
- Adds configurable data width, depth, NONSEQ/SEQ wait states, byte-lane writes, read-after-write forwarding and an optional out-of-range ERROR response.
- Sits on the DMAC master bus as a source or destination memory. Instantiated in both system benches and FPGA bring-up builds.

Parameters:
- DATA_W, 32: data bus width; one of 32 or 64.
- ADDR_W, 32: address bus width.
- MEM_DEPTH, 256: number of DATA_W-bit words; must be a power of two.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted for each NONSEQ transfer (0..15).
- SEQ_WAIT_STATES, 0: HREADYOUT-low cycles inserted for each SEQ transfer (0..15).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; 0 byte, 1 half, 2 word, 3 dword.
- HREADYIN  in  1  bus HREADY.
- HWDATA  in  DATA_W  write data (data phase).
- HRDATA  out  DATA_W  read data.
- HREADYOUT  out  1  transfer done / slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Clock and reset: one clock, HCLK. Reset is synchronous and active-high on HRESET.
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, state IDLE, wait counter 0, pending transfer discarded. Storage array `mem` is NOT cleared, so benches may preload it hierarchically.
- Index: LSB = log2(DATA_W/8). Word index = HADDR[LSB +: log2(MEM_DEPTH)]. Upper bits are ignored unless ERR_INJECT_EN is defined.
- Address-phase capture: occurs when HSEL & HTRANS[1] & HREADYIN & HREADYOUT at the rising edge. The slave then latches index, HWRITE, HSIZE, byte offset and NONSEQ/SEQ.
- IDLE/BUSY, or HSEL=0: no capture. The next cycle gives OKAY with HREADYOUT=1.
- State IDLE:
  - capture with zero applicable wait -> DATA.
  - capture with nonzero wait -> WAIT, counter loaded with WAIT_STATES or SEQ_WAIT_STATES.
- State WAIT: HREADYOUT=0, HRESP=00; counter decrements each cycle; -> DATA when counter reaches 1.
- State DATA:
  - HREADYOUT=1, HRESP=00.
  - Write: commits HWDATA to mem at this edge.
  - Read: HRDATA holds mem[index] for this cycle.
  - A new capture in the same cycle gives a back-to-back pipeline: -> DATA or WAIT. Otherwise -> IDLE.
- Read latency: data is valid 1 + wait cycles after the address-phase edge. Zero-wait INCR bursts sustain one beat per cycle.
- Byte lanes: lanes are enabled per HSIZE and HADDR[LSB-1:0]; unselected lanes are preserved. HSIZE wider than DATA_W is treated as a full-word access.
- Read-after-write forwarding: a read captured in the same cycle as a write commit to the same index returns the merged new word.
- HRDATA holds its last value whenever no read completes.
- Reset mid-transfer (any state): next cycle is the reset state; no write is committed.

Optional Feature:
- Macro: AHB_MEM_ERR_INJECT_EN.
- Defined: an access whose HADDR[ADDR_W-1:LSB] >= MEM_DEPTH gets the two-cycle ERROR response:
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
  - No memory write occurs, and HRDATA is unchanged.
  - A capture during ERR2 is accepted normally.
  - Wait states are not applied to errored transfers.
- Not defined: ERR states are absent, the address wraps modulo MEM_DEPTH, and HRESP is constant 00.

Test Plan:
- Zero-wait burst read: preload mem[0..3]=AABBCCDD,11223344,55667788,99AABBCC; 4-beat INCR read from 0x0 -> HRDATA returns those values on 4 consecutive cycles, and HREADYOUT stays 1.
- NONSEQ/SEQ wait states: WAIT_STATES=2, SEQ_WAIT_STATES=1; 2-beat write DEADBEEF, CAFEF00D at 0x10 -> HREADYOUT low 2 cycles then 1 cycle; mem[4]=DEADBEEF, mem[5]=CAFEF00D.
- Forwarding: write 12345678 to 0x8 followed back-to-back by a read of 0x8 -> HRDATA=12345678 in the read data phase.
- Byte lane: mem[1]=11223344; byte write with HSIZE=0, HADDR=0x5, HWDATA=0000AA00 -> mem[1]=1122AA44.
- Error injection: MEM_DEPTH=256, write to 0x400.
  - Macro defined -> HRESP=01 for 2 cycles, HREADYOUT 0 then 1; mem[0] unchanged.
  - Macro undefined -> OKAY, and mem[0] is written.
- Reset during WAIT: WAIT_STATES=3; assert HRESET in the 2nd wait cycle -> next cycle HREADYOUT=1, HRESP=00, HRDATA=0; target word unchanged.
